r22sdf_stream_ctrl: RTL and testbench

R22SDF_STREAM_CTRL -- requirements
Module: r22sdf_stream_ctrl

---
 rtl/r22sdf_stream_ctrl.sv | 84 ++++++++
 tb/tb_r22sdf_stream_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/r22sdf_stream_ctrl.sv
// r22sdf_stream_ctrl: stream controller for an R2^2 SDF FFT pipeline (feeds, pads, drains, tags outputs)
//   sys_clk, sys_nrst (async, active-low)
//   s_valid/s_ready : upstream handshake; flush : pad current frame, drain, return to IDLE
//   fft_en : pipeline advance; zero_sel : pipeline input mux feeds zeros
//   m_valid/m_sof/m_eof/m_idx : registered output sample qualifiers (m_idx is bit-reversed order)
//   busy : controller not IDLE
module r22sdf_stream_ctrl #(
  parameter int FFT_LOG2 = 4,
  parameter int PIPE_LAT = 15
) (
  input  logic                sys_clk,
  input  logic                sys_nrst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                flush,
  output logic                fft_en,
  output logic                zero_sel,
  output logic                m_valid,
  output logic                m_sof,
  output logic                m_eof,
  output logic [FFT_LOG2-1:0] m_idx,
  output logic                busy
);
  localparam int N  = 1 << FFT_LOG2;
  localparam int CW = $clog2(PIPE_LAT + N + 1);
  typedef enum logic [1:0] {IDLE, RUN, PAD, DRAIN} state_t;
  state_t              state;
  logic [FFT_LOG2-1:0] in_cnt, in_nxt, out_cnt, out_rev;
  logic [CW-1:0]       tcnt, dcnt, pending;
  logic                zero_ph, real_tick, emit;
  assign zero_ph   = (state == PAD) || (state == DRAIN);
  assign s_ready   = !zero_ph;
  assign zero_sel  = zero_ph;
  assign fft_en    = zero_ph || s_valid;
  assign busy      = state != IDLE;
  assign real_tick = fft_en && (state != DRAIN);
  assign in_nxt    = in_cnt + 1'b1;
  // pending is the in-flight count (pushed minus emitted); it stays bounded in endless streams
  assign emit      = fft_en && (tcnt == CW'(PIPE_LAT)) && (pending != '0);
  for (genvar i = 0; i < FFT_LOG2; i++) begin : g_rev
    assign out_rev[i] = out_cnt[FFT_LOG2-1-i];
  end
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      tcnt    <= '0;
      dcnt    <= '0;
      pending <= '0;
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
      m_idx   <= '0;
    end else begin
      m_valid <= emit;
      m_sof   <= emit && (out_cnt == '0);
      m_eof   <= emit && (out_cnt == '1);
      m_idx   <= emit ? out_rev : '0;
      out_cnt <= emit ? out_cnt + 1'b1 : out_cnt;
      in_cnt  <= real_tick ? in_nxt : in_cnt;
      tcnt    <= (fft_en && tcnt != CW'(PIPE_LAT)) ? tcnt + 1'b1 : tcnt;
      pending <= pending + CW'(real_tick) - CW'(emit);
      case (state)
        IDLE:  state <= fft_en ? RUN : IDLE;
        // a sample coinciding with flush is counted before the frame position is judged
        RUN:   state <= !flush ? RUN : (((fft_en ? in_nxt : in_cnt) == '0) ? DRAIN : PAD);
        PAD:   state <= (in_cnt == '1) ? DRAIN : PAD;
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == CW'(PIPE_LAT - 1)) begin
            state   <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            tcnt    <= '0;
            dcnt    <= '0;
            pending <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_r22sdf_stream_ctrl.sv
// tb_r22sdf_stream_ctrl: directed self-checking bench for r22sdf_stream_ctrl (N=16, PIPE_LAT=15)
module tb_r22sdf_stream_ctrl;
  logic       sys_clk = 1'b0;
  logic       sys_nrst = 1'b0;
  logic       s_valid = 1'b0;
  logic       flush = 1'b0;
  logic       s_ready, fft_en, zero_sel, m_valid, m_sof, m_eof, busy;
  logic [3:0] m_idx;
  int checks = 0, failures = 0;
  int en_cnt, nready_cnt, zsel_cnt, sent, nv, sof_cnt, eof_cnt, first_sent, stray;
  logic [3:0] idxq [64];
  logic       sofq [64];
  logic       eofq [64];
  logic [3:0] rev [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14, 4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

  r22sdf_stream_ctrl #(.FFT_LOG2(4), .PIPE_LAT(15)) dut (
    .sys_clk(sys_clk), .sys_nrst(sys_nrst), .s_valid(s_valid), .s_ready(s_ready),
    .flush(flush), .fft_en(fft_en), .zero_sel(zero_sel), .m_valid(m_valid),
    .m_sof(m_sof), .m_eof(m_eof), .m_idx(m_idx), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic clear_stats();
    en_cnt = 0; nready_cnt = 0; zsel_cnt = 0; sent = 0; nv = 0;
    sof_cnt = 0; eof_cnt = 0; first_sent = -1; stray = 0;
  endtask

  // one clock: drive at the falling edge, observe combinational outputs, then registered ones at the next falling edge
  task automatic tick(input logic v, input logic f);
    s_valid = v; flush = f; #1;
    if (fft_en) en_cnt++;
    if (!s_ready) nready_cnt++;
    if (zero_sel) zsel_cnt++;
    if (v && s_ready) sent++;
    @(posedge sys_clk); @(negedge sys_clk);
    if (m_valid) begin
      if (nv < 64) begin idxq[nv] = m_idx; sofq[nv] = m_sof; eofq[nv] = m_eof; end
      if (nv == 0) first_sent = sent;
      sof_cnt += int'(m_sof); eof_cnt += int'(m_eof); nv++;
    end else if (m_sof || m_eof || m_idx != 4'd0) stray++;
  endtask

  task automatic drain_to_idle();
    int n = 0;
    while (busy && n < 100) begin tick(1'b0, 1'b0); n++; end
    checks++;
    if (busy) begin failures++; $display("FAIL idle_timeout busy=%0b required=0", busy); end
  endtask

  task automatic test_reset();
    sys_nrst = 1'b0; s_valid = 1'b0; flush = 1'b0; #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready got=%0b exp=1", s_ready); end
    checks++; if (fft_en !== 1'b0) begin failures++; $display("FAIL rst_fft_en got=%0b exp=0", fft_en); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%0b exp=0", m_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (zero_sel !== 1'b0) begin failures++; $display("FAIL rst_zero_sel got=%0b exp=0", zero_sel); end
    s_valid = 1'b1; #1;
    checks++; if (fft_en !== 1'b1) begin failures++; $display("FAIL rst_fft_en_follow got=%0b exp=1", fft_en); end
    s_valid = 1'b0;
    @(negedge sys_clk); @(negedge sys_clk);
    sys_nrst = 1'b1;
  endtask

  task automatic test_back_to_back();
    clear_stats();
    for (int i = 0; i < 32; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    checks++; if (en_cnt != 32) begin failures++; $display("FAIL b2b_fft_en_cycles got=%0d exp=32", en_cnt); end
    checks++; if (first_sent != 16) begin failures++; $display("FAIL b2b_first_valid_after got=%0d exp=16", first_sent); end
    checks++; if (nv != 17) begin failures++; $display("FAIL b2b_outputs got=%0d exp=17", nv); end
    checks++; if (sof_cnt != 2 || eof_cnt != 1) begin failures++; $display("FAIL b2b_sof_eof got=%0d/%0d exp=2/1", sof_cnt, eof_cnt); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%0b exp=1", busy); end
    clear_stats();
    tick(1'b0, 1'b1);
    drain_to_idle();
    checks++; if (nready_cnt != 15) begin failures++; $display("FAIL b2b_drain_cycles got=%0d exp=15", nready_cnt); end
    checks++; if (nv != 15) begin failures++; $display("FAIL b2b_drain_outputs got=%0d exp=15", nv); end
  endtask

  task automatic test_toggle();
    clear_stats();
    for (int i = 0; i < 64; i++) tick(i % 2 == 0, 1'b0);
    checks++; if (en_cnt != 32) begin failures++; $display("FAIL tog_fft_en_cycles got=%0d exp=32", en_cnt); end
    checks++; if (first_sent != 16) begin failures++; $display("FAIL tog_first_valid_after got=%0d exp=16", first_sent); end
    checks++; if (nv != 17) begin failures++; $display("FAIL tog_outputs got=%0d exp=17", nv); end
    for (int i = 0; i < 17 && i < nv; i++) begin
      checks++;
      if (idxq[i] !== rev[i % 16] || sofq[i] !== (i % 16 == 0) || eofq[i] !== (i % 16 == 15)) begin
        failures++;
        $display("FAIL tog_seq[%0d] idx/sof/eof got=%0d/%0b/%0b exp=%0d/%0b/%0b", i, idxq[i], sofq[i], eofq[i], rev[i % 16], i % 16 == 0, i % 16 == 15);
      end
    end
    tick(1'b0, 1'b1);
    drain_to_idle();
  endtask

  task automatic test_flush_pad();
    clear_stats();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    checks++; if (zero_sel !== 1'b1 || s_ready !== 1'b0) begin failures++; $display("FAIL pad_entry zsel/ready got=%0b/%0b exp=1/0", zero_sel, s_ready); end
    drain_to_idle();
    checks++; if (nready_cnt != 27 || zsel_cnt != 27) begin failures++; $display("FAIL pad_drain_cycles got=%0d/%0d exp=27/27", nready_cnt, zsel_cnt); end
    checks++; if (nv != 32) begin failures++; $display("FAIL pad_outputs got=%0d exp=32", nv); end
    checks++; if (sof_cnt != 2 || eof_cnt != 2) begin failures++; $display("FAIL pad_sof_eof got=%0d/%0d exp=2/2", sof_cnt, eof_cnt); end
    checks++; if (en_cnt != 47) begin failures++; $display("FAIL pad_fft_en_cycles got=%0d exp=47", en_cnt); end
    for (int i = 0; i < 32 && i < nv; i++) begin
      checks++;
      if (idxq[i] !== rev[i % 16] || sofq[i] !== (i % 16 == 0) || eofq[i] !== (i % 16 == 15)) begin
        failures++;
        $display("FAIL pad_seq[%0d] idx/sof/eof got=%0d/%0b/%0b exp=%0d/%0b/%0b", i, idxq[i], sofq[i], eofq[i], rev[i % 16], i % 16 == 0, i % 16 == 15);
      end
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL pad_stray_tags got=%0d exp=0", stray); end
  endtask

  task automatic test_flush_exact();
    clear_stats();
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    drain_to_idle();
    checks++; if (nready_cnt != 15) begin failures++; $display("FAIL exact_drain_cycles got=%0d exp=15", nready_cnt); end
    checks++; if (nv != 16) begin failures++; $display("FAIL exact_outputs got=%0d exp=16", nv); end
    checks++; if (sof_cnt != 1 || eof_cnt != 1) begin failures++; $display("FAIL exact_sof_eof got=%0d/%0d exp=1/1", sof_cnt, eof_cnt); end
    clear_stats();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    checks++; if (busy !== 1'b0 || nready_cnt != 0) begin failures++; $display("FAIL idle_flush busy/nready got=%0b/%0d exp=0/0", busy, nready_cnt); end
  endtask

  task automatic test_flush_coincide();
    clear_stats();
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    drain_to_idle();
    checks++; if (nready_cnt != 15) begin failures++; $display("FAIL coinc_drain_cycles got=%0d exp=15", nready_cnt); end
    checks++; if (nv != 16) begin failures++; $display("FAIL coinc_outputs got=%0d exp=16", nv); end
  endtask

  task automatic test_reset_mid_drain();
    clear_stats();
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    sys_nrst = 1'b0; s_valid = 1'b0; flush = 1'b0; #1;
    checks++; if (busy !== 1'b0 || s_ready !== 1'b1 || zero_sel !== 1'b0) begin failures++; $display("FAIL mid_rst busy/ready/zsel got=%0b/%0b/%0b exp=0/1/0", busy, s_ready, zero_sel); end
    checks++; if (m_valid !== 1'b0 || m_sof !== 1'b0 || m_eof !== 1'b0 || m_idx !== 4'd0) begin failures++; $display("FAIL mid_rst_outputs got=%0b/%0b/%0b/%0d exp=0/0/0/0", m_valid, m_sof, m_eof, m_idx); end
    checks++; if (fft_en !== 1'b0) begin failures++; $display("FAIL mid_rst_fft_en got=%0b exp=0", fft_en); end
    @(negedge sys_clk);
    sys_nrst = 1'b1;
    clear_stats();
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b0);
    checks++; if (nv != 0) begin failures++; $display("FAIL refill_early_valid got=%0d exp=0", nv); end
    tick(1'b1, 1'b0);
    checks++; if (nv != 1 || first_sent != 16) begin failures++; $display("FAIL refill_first got=%0d@%0d exp=1@16", nv, first_sent); end
    checks++; if (idxq[0] !== 4'd0 || sofq[0] !== 1'b1) begin failures++; $display("FAIL refill_first_tag idx/sof got=%0d/%0b exp=0/1", idxq[0], sofq[0]); end
    tick(1'b0, 1'b1);
    drain_to_idle();
    checks++; if (nv != 16) begin failures++; $display("FAIL refill_outputs got=%0d exp=16", nv); end
  endtask

  initial begin
    clear_stats();
    @(negedge sys_clk);
    test_reset();
    test_back_to_back();
    test_toggle();
    test_flush_pad();
    test_flush_exact();
    test_flush_coincide();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
